uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with 16x oversampling, majority-vote bit sampling, optional parity, framing/parity error flags and an output FIFO with a valid/ready handshake. It replaces the fixed 8N1, edge-clocked receiver in the serial input path. It runs entirely in the `clk` domain and feeds received characters to the note/command decoder without dropping back-to-back frames.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame; legal values are 5 to 8.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of two and at least 2.
- `clk`  in  1  system clock; the block uses one clock.
- `rst`  in  1  reset; synchronous and active-high.
- `uart_rx`  in  1  asynchronous serial line; idle level is 1.
- `m_data`  out  DATA_BITS  head-of-FIFO character, LSB = first bit received.
- `m_perr`  out  1  head entry has a parity error.
- `m_ferr`  out  1  head entry has a framing error (stop bit sampled 0).
- `m_valid`  out  1  FIFO is not empty.
- `m_ready`  in  1  consumer accepts the head entry.
- `fifo_cnt`  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- `ovr`  out  1  sticky overrun flag.
- `ovr_clr`  in  1  single-cycle pulse that clears `ovr`.
- `busy`  out  1  receiver is not in IDLE.

## Operation
- **Input synchroniser:** `uart_rx` passes through 2 flops. Both reset to 1.
- **Tick generator:**
  - `DIV = CLK_FREQ/(16*BAUD)` (integer division; 325 at the defaults).
  - A counter runs 0..DIV-1 and raises `tick` for one clk at DIV-1.
  - In IDLE the counter is held at 0. It starts on the falling edge of the synchronised line.
- **Bit sampling:** a 4-bit sub-bit counter counts ticks 0..15 within each bit. The bit value is the majority of the samples at ticks 7, 8 and 9. The decision is taken at tick 9.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE → START on a synchronised 1→0 transition.
  - START, at its decision: majority 1 means a false start → IDLE; majority 0 → DATA at the end of tick 15.
  - DATA shifts the decided bit in LSB-first. After DATA_BITS bits it goes → PARITY if PARITY≠0, otherwise → STOP.
  - PARITY compares the received bit with the XOR of the data, inverted for odd parity. A mismatch sets perr.
  - STOP, at its decision, pushes {data, perr, ferr} into the FIFO. ferr = (stop majority == 0).
    - If ferr=0 → IDLE immediately, without waiting for tick 15. This allows resynchronisation on the next start edge.
    - If ferr=1 → BREAK.
  - BREAK waits until the synchronised line is 1, then → IDLE. A held-low line therefore yields exactly one entry.
- **FIFO:**
  - Width is DATA_BITS+2. Output is first-word-fall-through.
  - Pop occurs when `m_valid && m_ready`.
  - Push when full and no pop in the same cycle: the new frame is dropped, `ovr` is set, and stored contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted and `fifo_cnt` is unchanged.
  - Push and pop in the same cycle while empty: the push is stored and `m_valid` rises on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- **`ovr`:** cleared by `rst` or `ovr_clr`. If `ovr_clr` and a new overrun occur in the same cycle, set wins.
- **Reset values:** `m_valid`=0, `fifo_cnt`=0, `ovr`=0, `busy`=0, `m_perr`=0, `m_ferr`=0, `m_data`=0 (storage is cleared or output-gated). The state machine is in IDLE.
- **Reset mid-frame:** the partial frame is discarded, the FIFO is emptied and the state returns to IDLE.

## Timing
- Synchroniser latency is 2 clk.
- START decision occurs at 9*DIV+1 clk after the synchronised falling edge, ±1.
- The FIFO write happens on the clk edge where the STOP decision is made. `m_valid` and the head outputs are valid from the next cycle.
- The frame-to-FIFO latency from the start edge is (16*(1+DATA_BITS+P)+9)*DIV clk, plus up to 3 clk. P is 1 when parity is enabled, otherwise 0.
- Back-to-back frames with a single stop bit must be received with no loss.
- `m_data`, `m_perr` and `m_ferr` are stable while `m_valid && !m_ready`.

## Structure
- Package `uart_pkg` holds:
  - the parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - the state encoding enum `rx_state_t`;
  - the majority-of-3 function.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) contains the storage, the pointers, `fifo_cnt`, full/empty, and the simultaneous push/pop rules. The receiver FSM and tick generator live in the top level.

## Test plan
Bench parameters unless noted: CLK_FREQ=6400000, BAUD=100000, giving DIV=4 and 64 clk/bit.
- **Basic 8N1 frame:** send 0xA5 with `m_ready`=1. Expect one `m_valid` pulse with `m_data`=0xA5, `m_perr`=0, `m_ferr`=0, arriving ~(16*9+9)*4 clk after the start edge.
- **False start:** hold the line low for 16 clk, then high. Expect no FIFO write, `busy` back to 0 within 40 clk, and `fifo_cnt`=0.
- **Parity error:** with PARITY=1, send 0x07 with parity bit 0. Expect `m_data`=0x07, `m_perr`=1, `m_ferr`=0. Repeating with parity bit 1 gives `m_perr`=0.
- **Break:** hold the line low for 20 bit times, then release. Expect exactly one entry with `m_data`=0x00 and `m_ferr`=1. A following 0x5A is received cleanly.
- **Overrun:** with `m_ready`=0, send 17 frames 0x00..0x10. Expect `fifo_cnt`=16, `ovr`=1, and 0x10 dropped. Draining yields 0x00..0x0F in order. `ovr_clr` returns `ovr` to 0.
- **Reset mid-frame:** assert `rst` for 1 clk after 3 data bits. Expect `busy`=0, `m_valid`=0 and `fifo_cnt`=0. The next frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: parity modes,
// receiver state encoding and the 3-sample majority vote.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Bit decision from the three mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push into a full FIFO is
// accepted only if a pop happens in the same cycle; otherwise it is dropped
// and the stored contents are left untouched.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);
  // Gate the head so the outputs read zero while empty (storage is not reset).
  assign dout    = valid ? mem_q[rptr_q] : '0;
  assign cnt     = cnt_q;

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; emptiness comes from cnt_q and the output is gated.
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, majority-vote bit decisions, optional
// parity, framing/parity flags and an output FIFO with valid/ready handshake.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        uart_rx,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_perr,
  output logic                        m_ferr,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        ovr,
  input  logic                        ovr_clr,
  output logic                        busy
);

  localparam int   DIV   = CLK_FREQ / (16 * BAUD);
  localparam int   DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int   FW    = DATA_BITS + 2;
  localparam logic ODD   = (PARITY == PAR_ODD);

  rx_state_t            state_q, state_d;
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [3:0]           sub_q, sub_d;
  logic [2:0]           bit_q, bit_d;
  logic                 s7_q, s7_d, s8_q, s8_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick, fall, bit_val, push, pop, full;
  logic [FW-1:0]        push_data, head;

  assign fall      = rx_prev_q & ~rx_s2_q;
  assign tick      = (state_q != ST_IDLE) && (div_q == DIV_W'(DIV - 1));
  assign bit_val   = maj3(s7_q, s8_q, rx_s2_q);
  assign push_data = {shreg_q, perr_q, ~bit_val};
  assign pop       = m_valid && m_ready;
  assign busy      = (state_q != ST_IDLE);
  assign ovr       = ovr_q;
  assign {m_data, m_perr, m_ferr} = head;

  // Synchroniser, tick generator, sampling and receiver next-state logic.
  // The start edge counts as tick 0, so the first divider tick is tick 1.
  always_comb begin
    rx_s1_d   = uart_rx;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    state_d   = state_q;
    div_d     = div_q;
    sub_d     = sub_q;
    bit_d     = bit_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    push      = 1'b0;

    if (state_q != ST_IDLE) div_d = tick ? '0 : div_q + 1'b1;
    if (tick) begin
      sub_d = sub_q + 4'd1;
      if (sub_q == 4'd7) s7_d = rx_s2_q;
      if (sub_q == 4'd8) s8_d = rx_s2_q;
    end

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (fall) begin
          state_d = ST_START;
          sub_d   = 4'd1;
          bit_d   = '0;
          perr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (tick && sub_q == 4'd9 && bit_val) state_d = ST_IDLE;
        else if (tick && sub_q == 4'd15)      state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick && sub_q == 4'd9) shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
        if (tick && sub_q == 4'd15) begin
          if (bit_q == 3'(DATA_BITS - 1))
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else
            bit_d = bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (tick && sub_q == 4'd9)  perr_d  = bit_val ^ (^shreg_q) ^ ODD;
        if (tick && sub_q == 4'd15) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave at the decision so the next start edge is never missed.
        if (tick && sub_q == 4'd9) begin
          push    = 1'b1;
          state_d = bit_val ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overrun: a dropped push sets it and wins over a same-cycle clear.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_clr)                ovr_d = 1'b0;
    if (push && full && !pop)   ovr_d = 1'b1;
  end

  // Receiver registers with synchronous reset; synchroniser resets to idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      div_q     <= '0;
      sub_q     <= '0;
      bit_q     <= '0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      div_q     <= div_d;
      sub_q     <= sub_d;
      bit_q     <= bit_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .valid (m_valid),
    .full  (full),
    .cnt   (fifo_cnt)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: lane 0 is an 8N1 receiver, lane 1 an 8E1 receiver.
// A queue model per lane holds the entries each sent frame must produce.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 6400000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 16;
  localparam int BIT_CLK  = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rx_line;
  logic [1:0] m_ready;
  logic [1:0] ovr_clr;

  logic [7:0] m_data0, m_data1;
  logic       m_perr0, m_perr1, m_ferr0, m_ferr1, m_valid0, m_valid1;
  logic [4:0] cnt0, cnt1;
  logic       ovr0, ovr1, busy0, busy1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [9:0] exp0[$];
  logic [9:0] exp1[$];
  bit         ovr_exp0, ovr_exp1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .uart_rx(rx_line[0]),
    .m_data(m_data0), .m_perr(m_perr0), .m_ferr(m_ferr0), .m_valid(m_valid0), .m_ready(m_ready[0]),
    .fifo_cnt(cnt0), .ovr(ovr0), .ovr_clr(ovr_clr[0]), .busy(busy0)
  );

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .uart_rx(rx_line[1]),
    .m_data(m_data1), .m_perr(m_perr1), .m_ferr(m_ferr1), .m_valid(m_valid1), .m_ready(m_ready[1]),
    .fifo_cnt(cnt1), .ovr(ovr1), .ovr_clr(ovr_clr[1]), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entry a frame must produce: {data, perr, ferr}; lane 1 uses even parity.
  function automatic logic [9:0] model_entry(input logic [7:0] d, input bit par_en,
                                             input bit par_bit, input bit stop_bit);
    bit perr;
    perr = par_en ? (par_bit != (^d)) : 1'b0;
    return {d, perr, ~stop_bit};
  endfunction

  task automatic model_push(input int lane, input logic [9:0] e);
    if (lane == 0) begin
      if (exp0.size() >= DEPTH) ovr_exp0 = 1'b1;
      else exp0.push_back(e);
    end else begin
      if (exp1.size() >= DEPTH) ovr_exp1 = 1'b1;
      else exp1.push_back(e);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int lane, input logic v, input int n);
    rx_line[lane] = v;
    clks(n);
  endtask

  task automatic send_frame(input int lane, input logic [7:0] d, input bit par_en,
                            input bit par_bit, input bit stop_bit);
    model_push(lane, model_entry(d, par_en, par_bit, stop_bit));
    drive(lane, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(lane, d[i], BIT_CLK);
    if (par_en) drive(lane, par_bit, BIT_CLK);
    drive(lane, stop_bit, BIT_CLK);
  endtask

  // Occupancy, valid and overrun against the model once traffic has settled.
  task automatic quiesce();
    clks(4);
    check("cnt0_vs_model", cnt0, exp0.size());
    check("valid0_vs_model", m_valid0, exp0.size() != 0);
    check("ovr0_vs_model", ovr0, ovr_exp0);
    check("cnt1_vs_model", cnt1, exp1.size());
    check("valid1_vs_model", m_valid1, exp1.size() != 0);
    check("ovr1_vs_model", ovr1, ovr_exp1);
  endtask

  task automatic pop_one(input int lane);
    m_ready[lane] = 1'b1;
    clks(1);
    m_ready[lane] = 1'b0;
  endtask

  // Head of each FIFO must match the model front whenever valid; accepted pops advance it.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid0) begin
        if (exp0.size() == 0) check("lane0_unexpected_valid", m_valid0, 1'b0);
        else begin
          check("lane0_head", {m_data0, m_perr0, m_ferr0}, exp0[0]);
          if (m_ready[0]) void'(exp0.pop_front());
        end
      end
      if (m_valid1) begin
        if (exp1.size() == 0) check("lane1_unexpected_valid", m_valid1, 1'b0);
        else begin
          check("lane1_head", {m_data1, m_perr1, m_ferr1}, exp1[0]);
          if (m_ready[1]) void'(exp1.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   start_cyc;
    bit   seen;
    logic [9:0] cap;

    rst = 1'b1; rx_line = 2'b11; m_ready = 2'b00; ovr_clr = 2'b00;
    ovr_exp0 = 1'b0; ovr_exp1 = 1'b0;
    clks(3);
    check("rst_valid0", m_valid0, 1'b0);
    check("rst_cnt0", cnt0, 5'd0);
    check("rst_ovr0", ovr0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_head0", {m_data0, m_perr0, m_ferr0}, 10'd0);
    check("rst_valid1", m_valid1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    rst = 1'b0;
    clks(10);

    // Basic 8N1 frame with latency measurement.
    m_ready[0] = 1'b1;
    seen = 1'b0; lat = 0; cap = '0;
    start_cyc = cyc;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 700; i++) begin
          @(negedge clk);
          if (m_valid0) begin
            seen = 1'b1;
            lat  = cyc - start_cyc;
            cap  = {m_data0, m_perr0, m_ferr0};
            break;
          end
        end
      end
    join
    check("basic_seen", seen, 1'b1);
    check("basic_entry", cap, {8'hA5, 1'b0, 1'b0});
    check("basic_latency_window", (lat >= 612) && (lat <= 618), 1'b1);
    quiesce();

    // Back-to-back frames with a single stop bit.
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
    quiesce();

    // False start: 16 clk low pulse.
    drive(0, 1'b0, 8);
    check("false_start_busy", busy0, 1'b1);
    drive(0, 1'b0, 8);
    rx_line[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy0) begin seen = 1'b1; break; end
    end
    check("false_start_idle", seen, 1'b1);
    clks(20);
    check("false_start_cnt", cnt0, 5'd0);
    quiesce();

    // Break: 20 bit times low produces exactly one framing-error entry.
    m_ready[0] = 1'b0;
    model_push(0, model_entry(8'h00, 1'b0, 1'b0, 1'b0));
    drive(0, 1'b0, 20 * BIT_CLK);
    drive(0, 1'b1, BIT_CLK);
    check("break_cnt", cnt0, 5'd1);
    check("break_entry", {m_data0, m_perr0, m_ferr0}, {8'h00, 1'b0, 1'b1});
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    quiesce();
    check("break_then_5a_cnt", cnt0, 5'd2);
    pop_one(0);
    clks(1);
    check("after_break_entry", {m_data0, m_perr0, m_ferr0}, {8'h5A, 1'b0, 1'b0});
    pop_one(0);
    quiesce();

    // Even parity lane: 0x07 has odd weight, so parity bit 0 is an error.
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    quiesce();
    check("par_bad_entry", {m_data1, m_perr1, m_ferr1}, {8'h07, 1'b1, 1'b0});
    pop_one(1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    quiesce();
    check("par_good_entry", {m_data1, m_perr1, m_ferr1}, {8'h07, 1'b0, 1'b0});
    pop_one(1);
    quiesce();

    // Overrun: 17 frames into a 16-deep FIFO with no consumer.
    for (int i = 0; i < 17; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
    quiesce();
    check("ovr_cnt_full", cnt0, 5'd16);
    check("ovr_set", ovr0, 1'b1);
    check("ovr_head_first", m_data0, 8'h00);
    m_ready[0] = 1'b1;
    clks(20);
    check("ovr_drained_cnt", cnt0, 5'd0);
    check("ovr_still_set", ovr0, 1'b1);
    ovr_clr[0] = 1'b1;
    clks(1);
    ovr_clr[0] = 1'b0;
    ovr_exp0   = 1'b0;
    check("ovr_cleared", ovr0, 1'b0);
    quiesce();

    // Reset after 3 data bits of 0x3C (0, 0, 1 LSB first).
    m_ready[0] = 1'b0;
    drive(0, 1'b0, BIT_CLK);
    drive(0, 1'b0, BIT_CLK);
    drive(0, 1'b0, BIT_CLK);
    drive(0, 1'b1, BIT_CLK);
    check("midframe_busy_before", busy0, 1'b1);
    rst = 1'b1;
    exp0.delete(); exp1.delete();
    ovr_exp0 = 1'b0; ovr_exp1 = 1'b0;
    clks(1);
    rst = 1'b0;
    check("midframe_busy", busy0, 1'b0);
    check("midframe_valid", m_valid0, 1'b0);
    check("midframe_cnt", cnt0, 5'd0);
    clks(BIT_CLK * 6);
    quiesce();
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    quiesce();
    check("after_reset_entry", {m_data0, m_perr0, m_ferr0}, {8'h3C, 1'b0, 1'b0});
    pop_one(0);
    quiesce();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
